// File: rtl/interleaver_branch_controller.sv
// interleaver_branch_controller: packet sync search, branch rotation and zero-fill drain for a convolutional interleaver
module interleaver_branch_controller #(
    parameter int          NUM_BRANCHES = 12,
    parameter int          DEPTH_M      = 17,
    parameter int          PACKET_LEN   = 204,
    parameter logic [7:0]  SYNC_BYTE    = 8'h47
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] dp_data,
    output logic       shift_en,
    output logic [3:0] select,
    output logic       sync_locked,
    output logic       flush_done
);
    localparam int          PW    = $clog2(PACKET_LEN);
    localparam logic [15:0] DRAIN = 16'(NUM_BRANCHES * (NUM_BRANCHES - 1) * DEPTH_M);
    localparam logic [3:0]  LAST  = 4'(NUM_BRANCHES - 1);

    typedef enum logic [1:0] {SEARCH, RUN, FLUSH} state_t;

    state_t        state, state_n;
    logic [3:0]    branch, branch_n, branch_inc;
    logic [PW-1:0] pos, pos_n;
    logic [1:0]    miss, miss_n;
    logic [15:0]   drain, drain_n;
    logic [7:0]    data_n;
    logic [3:0]    sel_n;
    logic          shift_n, lock_n, done_n, fwd, accept;

    assign in_ready   = ~reset & (state != FLUSH);
    assign accept     = in_valid & in_ready;
    assign branch_inc = (branch == LAST) ? 4'd0 : branch + 4'd1;

    // Next-state and next-output decode; outputs hold unless a shift or a drain completion occurs
    always_comb begin
        state_n  = state;
        branch_n = branch;
        pos_n    = pos;
        miss_n   = miss;
        drain_n  = drain;
        shift_n  = 1'b0;
        data_n   = dp_data;
        sel_n    = select;
        lock_n   = sync_locked;
        done_n   = 1'b0;
        fwd      = 1'b0;
        case (state)
            SEARCH: begin
                if (accept && in_data == SYNC_BYTE) begin
                    fwd     = 1'b1;
                    state_n = RUN;
                    lock_n  = 1'b1;
                    miss_n  = 2'd0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (pos == '0 && in_data != SYNC_BYTE) begin
                        if (miss == 2'd2) begin
                            state_n  = SEARCH;
                            lock_n   = 1'b0;
                            branch_n = 4'd0;
                            pos_n    = '0;
                            miss_n   = 2'd0;
                        end else begin
                            miss_n = miss + 2'd1;
                            fwd    = 1'b1;
                        end
                    end else begin
                        miss_n = (pos == '0) ? 2'd0 : miss;
                        fwd    = 1'b1;
                    end
                end
                // Losing lock takes priority over a simultaneous flush request
                if (flush && state_n == RUN) begin
                    state_n = FLUSH;
                    drain_n = 16'd0;
                end
            end
            FLUSH: begin
                if (drain == DRAIN) begin
                    done_n   = 1'b1;
                    state_n  = SEARCH;
                    lock_n   = 1'b0;
                    branch_n = 4'd0;
                    pos_n    = '0;
                    miss_n   = 2'd0;
                    drain_n  = 16'd0;
                    sel_n    = 4'd0;
                end else begin
                    shift_n  = 1'b1;
                    data_n   = 8'h00;
                    sel_n    = branch;
                    branch_n = branch_inc;
                    drain_n  = drain + 16'd1;
                end
            end
            default: state_n = SEARCH;
        endcase
        if (fwd) begin
            shift_n  = 1'b1;
            data_n   = in_data;
            sel_n    = branch;
            branch_n = branch_inc;
            pos_n    = (pos == PW'(PACKET_LEN - 1)) ? '0 : pos + PW'(1);
        end
    end

    // State, counters and registered datapath outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            branch      <= 4'd0;
            pos         <= '0;
            miss        <= 2'd0;
            drain       <= 16'd0;
            shift_en    <= 1'b0;
            dp_data     <= 8'h00;
            select      <= 4'd0;
            sync_locked <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            state       <= state_n;
            branch      <= branch_n;
            pos         <= pos_n;
            miss        <= miss_n;
            drain       <= drain_n;
            shift_en    <= shift_n;
            dp_data     <= data_n;
            select      <= sel_n;
            sync_locked <= lock_n;
            flush_done  <= done_n;
        end
    end
endmodule

// File: tb/tb_interleaver_branch_controller.sv
// tb_interleaver_branch_controller: directed checks of lock, wrap, loss of lock, gaps, flush and reset
module tb_interleaver_branch_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [7:0] dp_data;
    logic       shift_en;
    logic [3:0] select;
    logic       sync_locked;
    logic       flush_done;
    int         checks = 0;
    int         errors = 0;

    interleaver_branch_controller dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .dp_data(dp_data),
        .shift_en(shift_en),
        .select(select),
        .sync_locked(sync_locked),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and return at the following falling edge
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_shift"}, shift_en, 0);
        check({tag, "_data"}, dp_data, 8'h00);
        check({tag, "_sel"}, select, 0);
        check({tag, "_lock"}, sync_locked, 0);
        check({tag, "_done"}, flush_done, 0);
    endtask

    // Send filler bytes at positions first..203, checking each lands on its branch
    task automatic fill_packet(input int first);
        for (int p = first; p < 204; p++) begin
            step(1'b1, 8'hC3, 1'b0);
            check("fill_shift", shift_en, 1);
            check("fill_sel", select, p % 12);
        end
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h47, 1'b0);
        check_reset_values("reset");
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        check("post_reset_rdy", in_ready, 1);
        check("post_reset_shift", shift_en, 0);

        // Lock
        step(1'b1, 8'h12, 1'b0);
        check("search_discard_shift", shift_en, 0);
        check("search_lock", sync_locked, 0);
        step(1'b1, 8'h47, 1'b0);
        check("lock_shift", shift_en, 1);
        check("lock_data", dp_data, 8'h47);
        check("lock_sel", select, 0);
        check("lock_locked", sync_locked, 1);
        step(1'b1, 8'hA0, 1'b0);
        check("a0_shift", shift_en, 1);
        check("a0_data", dp_data, 8'hA0);
        check("a0_sel", select, 1);

        // Wrap through a whole packet; next sync lands on branch 0
        fill_packet(2);
        step(1'b1, 8'h47, 1'b0);
        check("wrap_sync_shift", shift_en, 1);
        check("wrap_sync_data", dp_data, 8'h47);
        check("wrap_sync_sel", select, 0);

        // Loss of lock after three consecutive bad sync bytes
        fill_packet(1);
        step(1'b1, 8'h00, 1'b0);
        check("miss1_shift", shift_en, 1);
        check("miss1_sel", select, 0);
        check("miss1_lock", sync_locked, 1);
        fill_packet(1);
        step(1'b1, 8'h00, 1'b0);
        check("miss2_shift", shift_en, 1);
        check("miss2_sel", select, 0);
        fill_packet(1);
        step(1'b1, 8'h00, 1'b0);
        check("miss3_shift", shift_en, 0);
        check("miss3_lock", sync_locked, 0);
        step(1'b1, 8'h33, 1'b0);
        check("relost_discard", shift_en, 0);
        step(1'b1, 8'h47, 1'b0);
        check("relock_shift", shift_en, 1);
        check("relock_sel", select, 0);
        check("relock_lock", sync_locked, 1);

        // Gaps: invalid data must not leak through
        step(1'b1, 8'h11, 1'b0);
        check("gap1_sel", select, 1);
        step(1'b0, 8'hFF, 1'b0);
        check("gap_shift", shift_en, 0);
        check("gap_data_hold", dp_data, 8'h11);
        check("gap_sel_hold", select, 1);
        step(1'b1, 8'h22, 1'b0);
        check("gap2_shift", shift_en, 1);
        check("gap2_data", dp_data, 8'h22);
        check("gap2_sel", select, 2);

        // Flush with a simultaneous accept at branch 4
        step(1'b1, 8'h33, 1'b0);
        check("pre_flush_sel", select, 3);
        step(1'b1, 8'h5A, 1'b1);
        check("flush_byte_shift", shift_en, 1);
        check("flush_byte_data", dp_data, 8'h5A);
        check("flush_byte_sel", select, 4);
        check("flush_rdy", in_ready, 0);
        for (int i = 0; i < 2244; i++) begin
            step(1'b1, 8'h99, 1'b0);
            check("drain_shift", shift_en, 1);
            check("drain_data", dp_data, 8'h00);
            check("drain_sel", select, (5 + i) % 12);
            check("drain_rdy", in_ready, 0);
            check("drain_done", flush_done, 0);
        end
        step(1'b1, 8'h99, 1'b1);
        check("done_pulse", flush_done, 1);
        check("done_shift", shift_en, 0);
        check("done_sel", select, 0);
        check("done_lock", sync_locked, 0);
        check("done_rdy", in_ready, 1);
        step(1'b1, 8'h12, 1'b1);
        check("done_single", flush_done, 0);
        check("search_flush_ignored_rdy", in_ready, 1);
        check("search_flush_shift", shift_en, 0);
        step(1'b0, 8'h00, 1'b0);
        check("search_flush_ignored_rdy2", in_ready, 1);

        // Reset during a drain
        step(1'b1, 8'h47, 1'b0);
        check("mid_lock_sel", select, 0);
        step(1'b0, 8'h00, 1'b1);
        check("mid_enter_shift", shift_en, 0);
        check("mid_enter_rdy", in_ready, 0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("mid_drain_sel", select, (1 + i) % 12);
        end
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        check_reset_values("mid_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("mid_after_done", flush_done, 0);
            check("mid_after_rdy", in_ready, 1);
            check("mid_after_shift", shift_en, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
